// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 width codes, FSM encoding
// and the default data memory size.
package lsu_pkg;

    localparam int MEM_SIZE_DEFAULT = 1024;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // Stores only have signed-looking codes B/H/W; loads add the unsigned BU/HU.
    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        if (we) begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: little-endian lane extraction
// with sign/zero extension, sub-word store merge and alignment checking.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rbuf_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] store_word_o,
    output logic [31:0] load_word_o,
    output logic        misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rbuf_i[7:0];
        case (addr_lo_i)
            2'd0:    byte_sel = rbuf_i[7:0];
            2'd1:    byte_sel = rbuf_i[15:8];
            2'd2:    byte_sel = rbuf_i[23:16];
            default: byte_sel = rbuf_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rbuf_i[31:16] : rbuf_i[15:0];
    end

    // Width is funct3[1:0]; code 3 is illegal and reported elsewhere, not here.
    always_comb begin
        misalign_o = 1'b0;
        case (funct3_i[1:0])
            2'd1:    misalign_o = addr_lo_i[0];
            2'd2:    misalign_o = (addr_lo_i != 2'd0);
            default: misalign_o = 1'b0;
        endcase
    end

    always_comb begin
        load_word_o = '0;
        case (funct3_i)
            F3_B:    load_word_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_word_o = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_word_o = rbuf_i;
            F3_BU:   load_word_o = {24'd0, byte_sel};
            F3_HU:   load_word_o = {16'd0, half_sel};
            default: load_word_o = '0;
        endcase
    end

    always_comb begin
        store_word_o = rbuf_i;
        case (funct3_i[1:0])
            2'd0: begin
                case (addr_lo_i)
                    2'd0:    store_word_o[7:0]   = wdata_i[7:0];
                    2'd1:    store_word_o[15:8]  = wdata_i[7:0];
                    2'd2:    store_word_o[23:16] = wdata_i[7:0];
                    default: store_word_o[31:24] = wdata_i[7:0];
                endcase
            end
            2'd1: begin
                if (addr_lo_i[1]) begin
                    store_word_o[31:16] = wdata_i[15:0];
                end else begin
                    store_word_o[15:0] = wdata_i[15:0];
                end
            end
            2'd2:    store_word_o = wdata_i;
            default: store_word_o = rbuf_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a word-wide data memory
// without byte enables; sub-word stores are done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_SIZE = MEM_SIZE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output lsu_state_e  dbg_state
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE);

    // Handshake: a request is taken on a rising edge where req_valid and
    // req_ready are both high; req_ready is high only in IDLE, and the
    // response is a single-cycle resp_valid pulse with no backpressure.

    lsu_state_e  state_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rbuf_q, rbuf_d;
    logic        mem_we_q;
    logic [31:0] mem_waddr_q, mem_wdata_q, mem_raddr_q;
    logic        resp_valid_q, resp_err_q;
    logic [31:0] resp_rdata_q;

    logic [1:0]  align_addr;
    logic [2:0]  align_f3;
    logic [31:0] store_word, load_word;
    logic        misalign;
    logic        req_err;
    logic        req_fire;

    // In IDLE the aligner only checks the incoming request; afterwards it
    // works on the latched request and the word being read this cycle.
    assign align_addr = (state_q == ST_IDLE) ? req_addr[1:0] : addr_q[1:0];
    assign align_f3   = (state_q == ST_IDLE) ? req_funct3    : funct3_q;
    assign rbuf_d     = (state_q == ST_READ) ? mem_rdata     : rbuf_q;

    lsu_align u_align (
        .addr_lo_i   (align_addr),
        .funct3_i    (align_f3),
        .rbuf_i      (rbuf_d),
        .wdata_i     (wdata_q),
        .store_word_o(store_word),
        .load_word_o (load_word),
        .misalign_o  (misalign)
    );

    assign req_err  = misalign || !funct3_legal(req_we, req_funct3) ||
                      (req_addr >= MEM_LIMIT);
    assign req_fire = req_valid && (state_q == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            funct3_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rbuf_q       <= '0;
            mem_we_q     <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
            mem_raddr_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            rbuf_q       <= rbuf_d;
            case (state_q)
                ST_IDLE: begin
                    if (req_fire) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        if (req_err) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else if (req_we && (req_funct3 == F3_W)) begin
                            state_q     <= ST_WRITE;
                            mem_we_q    <= 1'b1;
                            mem_waddr_q <= {req_addr[31:2], 2'b00};
                            mem_wdata_q <= req_wdata;
                        end else begin
                            state_q     <= ST_READ;
                            mem_raddr_q <= {req_addr[31:2], 2'b00};
                        end
                    end
                end
                ST_READ: begin
                    if (we_q) begin
                        state_q     <= ST_WRITE;
                        mem_we_q    <= 1'b1;
                        mem_waddr_q <= {addr_q[31:2], 2'b00};
                        mem_wdata_q <= store_word;
                    end else begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= load_word;
                    end
                end
                ST_WRITE: begin
                    state_q      <= ST_RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_we     = mem_we_q;
    assign mem_waddr  = mem_waddr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_raddr  = mem_raddr_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-array memory model,
// plus directed width, error, back-to-back and reset-during-write cases.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int MEM_SIZE = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_we;
    logic [31:0] mem_waddr, mem_wdata, mem_raddr, mem_rdata;
    lsu_state_e  dbg_state;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // Word-wide data memory seen by the DUT.
    logic [31:0] env_mem [MEM_SIZE/4];
    assign mem_rdata = (mem_raddr < MEM_SIZE) ? env_mem[mem_raddr[9:2]] : 32'h0;
    always @(posedge clk) begin
        if (mem_we && mem_waddr < MEM_SIZE) env_mem[mem_waddr[9:2]] <= mem_wdata;
    end

    // Reference memory kept as individual bytes.
    logic [7:0] ref_b [MEM_SIZE];

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] lat;
        logic [31:0] we_cnt;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] hs;
    } exp_t;

    exp_t exp_q[$];
    exp_t me;
    int total = 0, bad = 0;
    int cyc = 0;
    int we_seen = 0;
    int resp_cnt = 0, sent_cnt = 0;
    bit busy = 0;
    bit mon_en = 1;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] val);
        env_mem[addr[9:2]] = val;
        for (int i = 0; i < 4; i++) ref_b[addr + i] = val[8*i +: 8];
    endtask

    function automatic exp_t model(input bit we, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        int n;
        longint v;
        bit legal;
        e = '0;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        n = (f3 % 4 == 0) ? 1 : ((f3 % 4 == 1) ? 2 : 4);
        if (!legal || addr >= MEM_SIZE || (addr % n) != 0) begin
            e.err = 1'b1;
            e.lat = 1;
            return e;
        end
        if (we) begin
            for (int i = 0; i < n; i++) ref_b[addr + i] = wd[8*i +: 8];
            e.we_cnt = 1;
            e.waddr = addr - (addr % 4);
            v = 0;
            for (int i = 0; i < 4; i++) v += longint'(ref_b[e.waddr + i]) << (8*i);
            e.wdata = v[31:0];
            e.lat = (n == 4) ? 2 : 3;
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v += longint'(ref_b[addr + i]) << (8*i);
            if (f3 < 4 && n < 4 && v >= (longint'(1) << (8*n - 1))) v -= longint'(1) << (8*n);
            e.rdata = v[31:0];
            e.lat = 2;
        end
        return e;
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input bit keep);
        int waited = 0;
        exp_t e;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            check("ready_timeout", {31'd0, req_ready}, 32'd1);
            req_valid = 1'b0;
            return;
        end
        e = model(we, f3, addr, wd);
        e.hs = cyc;
        exp_q.push_back(e);
        sent_cnt++;
        @(posedge clk);
        busy = 1;
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("resp_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            busy = 0;
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            check("ready", {31'd0, req_ready}, {31'd0, !busy});
            if (mem_we) begin
                we_seen++;
                if (exp_q.size() > 0) begin
                    check("waddr", mem_waddr, exp_q[0].waddr);
                    check("wdata", mem_wdata, exp_q[0].wdata);
                end
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("stray_resp", {31'd0, resp_valid}, 32'd0);
                end else begin
                    me = exp_q.pop_front();
                    check("err", {31'd0, resp_err}, {31'd0, me.err});
                    check("rdata", resp_rdata, me.rdata);
                    check("latency", 32'(cyc) - me.hs, me.lat);
                    check("we_cycles", 32'(we_seen), me.we_cnt);
                end
                we_seen = 0;
                busy = 0;
                resp_cnt++;
                last_rdata = resp_rdata;
                last_err = resp_err;
            end
        end
    end

    logic [2:0] ld_tab [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        bit          r_we;
        logic [2:0]  r_f3;
        logic [31:0] r_addr;
        int          base_cnt;

        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < MEM_SIZE / 4; i++) preload(32'(4 * i), $urandom);

        #12;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_waddr", mem_waddr, 32'd0);
        check("rst_raddr", mem_raddr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Byte loads, signed and unsigned.
        preload(32'h8, 32'h8899AABB);
        send(1'b0, F3_B, 32'hB, 32'h0, 1'b0);  wait_idle();
        check("t1_lb", last_rdata, 32'hFFFFFF88);
        send(1'b0, F3_BU, 32'hB, 32'h0, 1'b0); wait_idle();
        check("t1_lbu", last_rdata, 32'h00000088);

        // Sub-word store read-modify-write, then read back.
        preload(32'h4, 32'h11223344);
        send(1'b1, F3_B, 32'h5, 32'h000000EE, 1'b0); wait_idle();
        send(1'b0, F3_W, 32'h4, 32'h0, 1'b0);        wait_idle();
        check("t2_lw", last_rdata, 32'h1122EE44);

        // Full-word store and half loads.
        send(1'b1, F3_W, 32'h0, 32'hDEADBEEF, 1'b0); wait_idle();
        send(1'b0, F3_H, 32'h2, 32'h0, 1'b0);        wait_idle();
        check("t3_lh", last_rdata, 32'hFFFFDEAD);
        send(1'b0, F3_HU, 32'h0, 32'h0, 1'b0);       wait_idle();
        check("t3_lhu", last_rdata, 32'h0000BEEF);

        // Error responses.
        send(1'b0, F3_W, 32'h6, 32'h0, 1'b0);    wait_idle();
        check("t4_lw_mis", {31'd0, last_err}, 32'd1);
        send(1'b1, F3_H, 32'h3, 32'h1234, 1'b0); wait_idle();
        check("t4_sh_mis", {31'd0, last_err}, 32'd1);
        send(1'b0, 3'd3, 32'h0, 32'h0, 1'b0);    wait_idle();
        check("t4_f3_bad", {31'd0, last_err}, 32'd1);
        send(1'b0, F3_W, 32'h400, 32'h0, 1'b0);  wait_idle();
        check("t4_range", {31'd0, last_err}, 32'd1);

        // Three requests with req_valid held high throughout.
        base_cnt = resp_cnt;
        send(1'b0, F3_W, 32'h0, 32'h0, 1'b1);
        send(1'b1, F3_H, 32'h12, 32'h0000ABCD, 1'b1);
        send(1'b0, F3_H, 32'h12, 32'h0, 1'b0);
        wait_idle();
        check("t5_resp_count", 32'(resp_cnt - base_cnt), 32'd3);
        check("t5_lh", last_rdata, 32'hFFFFABCD);

        // Reset asserted in the middle of a WRITE cycle.
        preload(32'h10, 32'hCAFEF00D);
        mon_en = 0;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B; req_addr = 32'h11; req_wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("t6_we_before", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_we_cleared", {31'd0, mem_we}, 32'd0);
        check("t6_resp_cleared", {31'd0, resp_valid}, 32'd0);
        check("t6_ready_back", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_mem_kept", env_mem[4], 32'hCAFEF00D);
        @(negedge clk);
        mon_en = 1;
        send(1'b0, F3_W, 32'h10, 32'h0, 1'b0); wait_idle();
        check("t6_lw", last_rdata, 32'hCAFEF00D);

        // Random mix of loads, stores and error cases.
        for (int k = 0; k < 300; k++) begin
            r_we = 1'($urandom_range(0, 1));
            r_f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) r_f3 = r_we ? 3'($urandom_range(0, 2)) : ld_tab[$urandom_range(0, 4)];
            r_addr = 32'($urandom_range(0, MEM_SIZE + 15));
            if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~32'((1 << r_f3[1:0]) - 1);
            send(r_we, r_f3, r_addr, $urandom, ($urandom_range(0, 3) == 0));
        end
        req_valid = 1'b0;
        wait_idle();
        check("final_resp_count", 32'(resp_cnt), 32'(sent_cnt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits directly upstream of data_memory in the RV32 datapath. It accepts one load/store request at a time from the execute stage and decodes funct3 into byte, half or word width. It drives data_memory's word-wide read and write ports and returns sign- or zero-extended load data. data_memory has no byte enables, so sub-word stores are done as a read-modify-write sequence.

Parameters:
MEM_SIZE, 1024, data memory size in bytes; any access with req_addr >= MEM_SIZE is an error.

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE; handshake = req_valid & req_ready
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32 width code: LB=0 LH=1 LW=2 LBU=4 LHU=5; SB=0 SH=1 SW=2
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, illegal funct3 or out-of-range; valid with resp_valid
mem_we  out  1  to data_memory.we
mem_waddr  out  32  to data_memory.waddr, word-aligned (bits[1:0]=0)
mem_wdata  out  32  to data_memory.wdata
mem_raddr  out  32  to data_memory.raddr, word-aligned
mem_rdata  in  32  from data_memory.rdata; combinational read, valid in the same cycle as mem_raddr

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE.
  - req_ready = 1.
  - mem_we = 0, mem_waddr = 0, mem_raddr = 0, mem_wdata = 0.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - Reset during WRITE drops mem_we immediately, so no partial write can occur after reset asserts.
- Handshake:
  - Request fields are latched on the accepting edge.
  - req_ready = 0 outside IDLE; req_valid is ignored there.
  - resp has no backpressure.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE, handshake:
    - error -> RESP.
    - SW -> WRITE.
    - load, SB or SH -> READ.
  - READ:
    - mem_raddr = {addr[31:2], 2'b00}.
    - mem_rdata is captured into rbuf at the edge.
    - load -> RESP; SB/SH -> WRITE.
  - WRITE:
    - mem_we = 1; mem_waddr = aligned address.
    - mem_wdata = req_wdata for SW; for SB/SH, rbuf with the addressed lane(s) replaced.
    - -> RESP.
  - RESP:
    - resp_valid = 1 for exactly one cycle.
    - -> IDLE; req_ready is high again in the next cycle.
- Latency (handshake cycle to resp_valid cycle):
  - load: 2.
  - SW: 2.
  - SB/SH: 3.
  - error: 1.
  - Back-to-back throughput: one request per latency+1 cycles.
- Byte lanes are little-endian:
  - byte n (addr[1:0]=n) occupies bits 8n+7:8n.
  - the half at addr[1]=h occupies bits 16h+15:16h.
- Load extension:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- Errors (no memory access, mem_we stays 0; resp_err=1, resp_rdata=0):
  - halfword access with addr[0]=1.
  - word access with addr[1:0]!=0.
  - load funct3 in {3,6,7}.
  - store funct3 >= 3.
  - addr >= MEM_SIZE.
- mem_raddr and mem_waddr hold their last value outside READ/WRITE. mem_we is high only in WRITE.
- A load immediately after a store to the same word returns the new data: the write commits on the WRITE->RESP edge, before the next READ.

Decomposition:
- Package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - FSM state encoding.
  - MEM_SIZE default.
- One combinational sub-module, lsu_align:
  - inputs: addr[1:0], funct3, rbuf, wdata.
  - outputs: merged store word, extended load word, misalign flag.
  - It is unit-testable in isolation.
- The top holds the FSM, request latches and rbuf.

Test Plan:
1. Preload word@0x8=0x8899AABB; LB addr 0xB -> resp_valid 2 cycles after handshake, resp_rdata=0xFFFFFF88, resp_err=0; LBU addr 0xB -> 0x00000088.
2. Preload word@0x4=0x11223344; SB addr 0x5 wdata 0x000000EE -> one READ, then a WRITE cycle with mem_we=1, mem_waddr=0x4, mem_wdata=0x1122EE44; resp_valid at cycle 3; then LW 0x4 -> 0x1122EE44.
3. SW addr 0x0 wdata 0xDEADBEEF -> no READ cycle, mem_we=1 exactly one cycle, resp at cycle 2; LH 0x2 -> 0xFFFFDEAD; LHU 0x0 -> 0x0000BEEF.
4. Error cases:
   - LW addr 0x6 -> resp_valid in the cycle after handshake, resp_err=1, resp_rdata=0, mem_we never 1.
   - SH addr 0x3 -> same error response.
   - load funct3=3 -> resp_err=1.
   - LW addr 0x400 -> resp_err=1.
5. Hold req_valid high with 3 queued requests -> req_ready low except in IDLE; each request accepted only after the previous resp_valid; no request dropped or duplicated.
6. Assert rst_n=0 mid-cycle while in WRITE -> mem_we, resp_valid and req_ready-low state clear asynchronously, memory word unchanged; after release, a new LW returns the original data.
